// File: rtl/axis_insert_hdr_arb_if.sv
// Bus bundle for axis_insert_hdr_arb: two source payload/header channels plus
// the single payload/header stream toward the header-insertion datapath.
interface axis_insert_hdr_arb_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = 2
);
  logic [1:0]                     s_valid;
  logic [2*DATA_WD-1:0]           s_data;
  logic [2*DATA_BYTE_WD-1:0]      s_keep;
  logic [1:0]                     s_last;
  logic [1:0]                     s_ready;
  logic [1:0]                     s_hdr_valid;
  logic [2*DATA_WD-1:0]           s_hdr_data;
  logic [2*DATA_BYTE_WD-1:0]      s_hdr_keep;
  logic [2*(BYTE_CNT_WD+1)-1:0]   s_hdr_cnt;
  logic [1:0]                     s_hdr_ready;
  logic                           m_valid;
  logic [DATA_WD-1:0]             m_data;
  logic [DATA_BYTE_WD-1:0]        m_keep;
  logic                           m_last;
  logic                           m_ready;
  logic                           m_hdr_valid;
  logic [DATA_WD-1:0]             m_hdr_data;
  logic [DATA_BYTE_WD-1:0]        m_hdr_keep;
  logic [BYTE_CNT_WD:0]           m_hdr_cnt;

  // Arbiter view: receives the sources, drives the datapath side.
  modport slave (
    input  s_valid, s_data, s_keep, s_last, s_hdr_valid, s_hdr_data, s_hdr_keep, s_hdr_cnt, m_ready,
    output s_ready, s_hdr_ready, m_valid, m_data, m_keep, m_last,
           m_hdr_valid, m_hdr_data, m_hdr_keep, m_hdr_cnt
  );

  modport master (
    output s_valid, s_data, s_keep, s_last, s_hdr_valid, s_hdr_data, s_hdr_keep, s_hdr_cnt, m_ready,
    input  s_ready, s_hdr_ready, m_valid, m_data, m_keep, m_last,
           m_hdr_valid, m_hdr_data, m_hdr_keep, m_hdr_cnt
  );
endinterface

// File: rtl/axis_insert_hdr_arb.sv
// Packet-level two-source arbiter with latched header sideband and post-packet idle gap.
// Define AXIS_ARB_FIXED_PRIO_EN for fixed priority (source 0 wins ties); default is round-robin.
module axis_insert_hdr_arb #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axis_insert_hdr_arb_if.slave bus,
  output logic [1:0]           grant_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_e                    state_q;
  logic                      owner_q;
  logic [1:0]                grant_q;
  logic                      busy_q;
  logic [3:0]                gap_cnt_q;
  logic [DATA_WD-1:0]        hdr_data_q;
  logic [DATA_BYTE_WD-1:0]   hdr_keep_q;
  logic [BYTE_CNT_WD:0]      hdr_cnt_q;
  logic [DATA_WD-1:0]        data_q;
  logic [DATA_BYTE_WD-1:0]   keep_q;
  logic                      last_q;
`ifndef AXIS_ARB_FIXED_PRIO_EN
  logic                      last_owner_q;
`endif

  logic                      win_idx_d;
  logic [1:0]                win_onehot_d;
  logic [DATA_WD-1:0]        hdr_data_d;
  logic [DATA_BYTE_WD-1:0]   hdr_keep_d;
  logic [BYTE_CNT_WD:0]      hdr_cnt_d;
  logic                      in_pkt_s;
  logic                      hdr_fire_s;
  logic                      src_valid_s;
  logic [DATA_WD-1:0]        src_data_s;
  logic [DATA_BYTE_WD-1:0]   src_keep_s;
  logic                      src_last_s;
  logic                      beat_last_s;

  // Tie-break between simultaneous header requests.
  always_comb begin
    win_idx_d = 1'b0;
    case (bus.s_hdr_valid)
      2'b01:   win_idx_d = 1'b0;
      2'b10:   win_idx_d = 1'b1;
`ifdef AXIS_ARB_FIXED_PRIO_EN
      2'b11:   win_idx_d = 1'b0;
`else
      2'b11:   win_idx_d = ~last_owner_q;
`endif
      default: win_idx_d = 1'b0;
    endcase
  end

  assign win_onehot_d = win_idx_d ? 2'b10 : 2'b01;
  assign hdr_data_d   = win_idx_d ? bus.s_hdr_data[2*DATA_WD-1:DATA_WD] : bus.s_hdr_data[DATA_WD-1:0];
  assign hdr_keep_d   = win_idx_d ? bus.s_hdr_keep[2*DATA_BYTE_WD-1:DATA_BYTE_WD]
                                  : bus.s_hdr_keep[DATA_BYTE_WD-1:0];
  assign hdr_cnt_d    = win_idx_d ? bus.s_hdr_cnt[2*(BYTE_CNT_WD+1)-1:BYTE_CNT_WD+1]
                                  : bus.s_hdr_cnt[BYTE_CNT_WD:0];

  assign in_pkt_s    = (state_q == ST_PKT);
  assign hdr_fire_s  = rst_n && (state_q == ST_IDLE) && (|bus.s_hdr_valid);

  assign src_valid_s = owner_q ? bus.s_valid[1] : bus.s_valid[0];
  assign src_last_s  = owner_q ? bus.s_last[1]  : bus.s_last[0];
  assign src_data_s  = owner_q ? bus.s_data[2*DATA_WD-1:DATA_WD] : bus.s_data[DATA_WD-1:0];
  assign src_keep_s  = owner_q ? bus.s_keep[2*DATA_BYTE_WD-1:DATA_BYTE_WD] : bus.s_keep[DATA_BYTE_WD-1:0];

  // Payload is a zero-latency mux; outside a packet the last forwarded beat is held.
  assign bus.m_valid     = in_pkt_s & src_valid_s;
  assign bus.m_data      = in_pkt_s ? src_data_s : data_q;
  assign bus.m_keep      = in_pkt_s ? src_keep_s : keep_q;
  assign bus.m_last      = in_pkt_s ? src_last_s : last_q;
  assign bus.s_ready     = in_pkt_s ? (owner_q ? {bus.m_ready, 1'b0} : {1'b0, bus.m_ready}) : 2'b00;
  assign bus.s_hdr_ready = hdr_fire_s ? win_onehot_d : 2'b00;
  assign beat_last_s     = bus.m_valid & bus.m_ready & src_last_s;

  assign bus.m_hdr_valid = in_pkt_s;
  assign bus.m_hdr_data  = hdr_data_q;
  assign bus.m_hdr_keep  = hdr_keep_q;
  assign bus.m_hdr_cnt   = hdr_cnt_q;
  assign grant_o         = grant_q;
  assign busy_o          = busy_q;

  // Packet FSM: grant/latch header, track the owner's last beat, then count the idle gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      grant_q      <= 2'b00;
      busy_q       <= 1'b0;
      gap_cnt_q    <= 4'd0;
      hdr_data_q   <= '0;
      hdr_keep_q   <= '0;
      hdr_cnt_q    <= '0;
      data_q       <= '0;
      keep_q       <= '0;
      last_q       <= 1'b0;
`ifndef AXIS_ARB_FIXED_PRIO_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|bus.s_hdr_valid) begin
            state_q      <= ST_PKT;
            owner_q      <= win_idx_d;
            grant_q      <= win_onehot_d;
            busy_q       <= 1'b1;
            hdr_data_q   <= hdr_data_d;
            hdr_keep_q   <= hdr_keep_d;
            hdr_cnt_q    <= hdr_cnt_d;
`ifndef AXIS_ARB_FIXED_PRIO_EN
            last_owner_q <= win_idx_d;
`endif
          end
        end
        ST_PKT: begin
          data_q <= src_data_s;
          keep_q <= src_keep_s;
          last_q <= src_last_s;
          if (beat_last_s) begin
            state_q   <= ST_GAP;
            grant_q   <= 2'b00;
            gap_cnt_q <= 4'd0;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            gap_cnt_q <= 4'd0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_insert_hdr_arb.sv
// Self-checking bench for axis_insert_hdr_arb: directed vector table, GAP_CYCLES=3 corner
// sequence, and randomized traffic against a packet-level reference model.
module tb_axis_insert_hdr_arb;
  localparam logic [31:0] H0 = 32'h01234567;
  localparam logic [31:0] H1 = 32'hAABBCCDD;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axis_insert_hdr_arb_if #(.DATA_WD(32), .DATA_BYTE_WD(4), .BYTE_CNT_WD(2)) b1 ();
  axis_insert_hdr_arb_if #(.DATA_WD(32), .DATA_BYTE_WD(4), .BYTE_CNT_WD(2)) b3 ();
  logic [1:0] g1, g3;
  logic       bz1, bz3;

  axis_insert_hdr_arb #(.DATA_WD(32), .DATA_BYTE_WD(4), .BYTE_CNT_WD(2), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b1), .grant_o(g1), .busy_o(bz1));
  axis_insert_hdr_arb #(.DATA_WD(32), .DATA_BYTE_WD(4), .BYTE_CNT_WD(2), .GAP_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3), .grant_o(g3), .busy_o(bz3));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic rst; logic [1:0] hv; logic [1:0] sv; logic [1:0] sl; logic mr; logic [31:0] d;
    logic [1:0] e_shr; logic [1:0] e_gr; logic e_bz; logic e_mv; logic e_mhv; logic [1:0] e_sr;
    logic [31:0] e_dat; logic [31:0] e_hdr; logic [2:0] e_cnt;
  } vec_t;

  vec_t vt[26];

  function automatic vec_t mk(logic rst, logic [1:0] hv, logic [1:0] sv, logic [1:0] sl, logic mr,
                              logic [31:0] d, logic [1:0] shr, logic [1:0] gr, logic bz, logic mv,
                              logic mhv, logic [1:0] sr, logic [31:0] dat, logic [31:0] hdr,
                              logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.hv = hv; v.sv = sv; v.sl = sl; v.mr = mr; v.d = d;
    v.e_shr = shr; v.e_gr = gr; v.e_bz = bz; v.e_mv = mv; v.e_mhv = mhv; v.e_sr = sr;
    v.e_dat = dat; v.e_hdr = hdr; v.e_cnt = cnt;
    return v;
  endfunction

  // Reference model state (GAP_CYCLES = 1 instance)
  int          m_own, m_gap, m_lo;
  logic [31:0] m_hold, m_hdr;
  logic [2:0]  m_cnt;
  logic        m_lhold;

  function automatic int pick(logic [1:0] req, int lo);
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
`ifdef AXIS_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (lo == 1) ? 0 : 1;
`endif
  endfunction

  task automatic model_reset();
    m_own = -1; m_gap = 0; m_lo = 1; m_hold = 32'd0; m_hdr = 32'd0; m_cnt = 3'd0; m_lhold = 1'b0;
  endtask

  initial begin
    // source 1 data = d, source 0 data = ~d; header 0 = H0/cnt1, header 1 = H1/cnt2
    vt[0]  = mk(1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 3'd0);
    vt[1]  = vt[0];
    vt[2]  = vt[0];
    vt[3]  = mk(1'b1, 2'b11, 2'b00, 2'b00, 1'b1, 32'h0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 3'd0);
    vt[4]  = mk(1'b1, 2'b10, 2'b01, 2'b01, 1'b1, 32'hEEEEEEEE, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01, 32'h11111111, H0, 3'd1);
    vt[5]  = mk(1'b1, 2'b10, 2'b00, 2'b00, 1'b1, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 32'h11111111, H0, 3'd1);
    vt[6]  = mk(1'b1, 2'b10, 2'b00, 2'b00, 1'b1, 32'h0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h11111111, H0, 3'd1);
    vt[7]  = mk(1'b1, 2'b00, 2'b10, 2'b00, 1'b1, 32'h11111111, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 32'h11111111, H1, 3'd2);
    vt[8]  = mk(1'b1, 2'b00, 2'b10, 2'b00, 1'b1, 32'h22222222, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 32'h22222222, H1, 3'd2);
    vt[9]  = mk(1'b1, 2'b00, 2'b10, 2'b10, 1'b1, 32'h33333333, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 32'h33333333, H1, 3'd2);
    vt[10] = mk(1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 32'h33333333, H1, 3'd2);
    vt[11] = mk(1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h33333333, H1, 3'd2);
    vt[12] = mk(1'b1, 2'b01, 2'b00, 2'b00, 1'b1, 32'h0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h33333333, H1, 3'd2);
    vt[13] = mk(1'b1, 2'b00, 2'b01, 2'b00, 1'b1, 32'hBBBBBBBB, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01, 32'h44444444, H0, 3'd1);
    vt[14] = mk(1'b1, 2'b00, 2'b01, 2'b00, 1'b0, 32'hBBBBBBBB, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 2'b00, 32'h44444444, H0, 3'd1);
    vt[15] = vt[14];
    vt[16] = mk(1'b1, 2'b00, 2'b01, 2'b01, 1'b1, 32'hBBBBBBBB, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01, 32'h44444444, H0, 3'd1);
    vt[17] = mk(1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 32'h44444444, H0, 3'd1);
    vt[18] = mk(1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h44444444, H0, 3'd1);
    vt[19] = mk(1'b1, 2'b01, 2'b00, 2'b00, 1'b1, 32'h0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h44444444, H0, 3'd1);
    vt[20] = mk(1'b1, 2'b00, 2'b01, 2'b00, 1'b1, 32'hAAAAAAAA, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01, 32'h55555555, H0, 3'd1);
    vt[21] = mk(1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 32'hAAAAAAAA, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 32'h55555555, H0, 3'd1);
    vt[22] = mk(1'b1, 2'b11, 2'b00, 2'b00, 1'b1, 32'h0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 3'd0);
    vt[23] = mk(1'b1, 2'b00, 2'b01, 2'b01, 1'b1, 32'h0, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01, 32'hFFFFFFFF, H0, 3'd1);
    vt[24] = mk(1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 32'hFFFFFFFF, H0, 3'd1);
    vt[25] = mk(1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'hFFFFFFFF, H0, 3'd1);

    rst_n = vt[0].rst;
    b1.s_hdr_valid = vt[0].hv; b1.s_valid = vt[0].sv; b1.s_last = vt[0].sl; b1.m_ready = vt[0].mr;
    b1.s_data = {vt[0].d, ~vt[0].d}; b1.s_keep = 8'hFF;
    b1.s_hdr_data = {H1, H0}; b1.s_hdr_keep = 8'hFF; b1.s_hdr_cnt = {3'd2, 3'd1};
    b3.s_hdr_valid = 2'b00; b3.s_valid = 2'b00; b3.s_last = 2'b00; b3.m_ready = 1'b1;
    b3.s_data = {32'h0, 32'hCAFEF00D}; b3.s_keep = 8'hFF;
    b3.s_hdr_data = {H1, H0}; b3.s_hdr_keep = 8'hFF; b3.s_hdr_cnt = {3'd2, 3'd1};

    // Directed vector table
    for (int i = 0; i < 26; i++) begin
      @(posedge clk); #1;
      rst_n = vt[i].rst;
      b1.s_hdr_valid = vt[i].hv; b1.s_valid = vt[i].sv; b1.s_last = vt[i].sl;
      b1.m_ready = vt[i].mr; b1.s_data = {vt[i].d, ~vt[i].d};
      #1;
      chk($sformatf("v%0d s_hdr_ready", i), b1.s_hdr_ready, vt[i].e_shr);
      chk($sformatf("v%0d grant", i), g1, vt[i].e_gr);
      chk($sformatf("v%0d busy", i), bz1, vt[i].e_bz);
      chk($sformatf("v%0d m_valid", i), b1.m_valid, vt[i].e_mv);
      chk($sformatf("v%0d m_hdr_valid", i), b1.m_hdr_valid, vt[i].e_mhv);
      chk($sformatf("v%0d s_ready", i), b1.s_ready, vt[i].e_sr);
      chk($sformatf("v%0d m_data", i), b1.m_data, vt[i].e_dat);
      chk($sformatf("v%0d m_hdr_data", i), b1.m_hdr_data, vt[i].e_hdr);
      chk($sformatf("v%0d m_hdr_cnt", i), b1.m_hdr_cnt, vt[i].e_cnt);
    end

    // GAP_CYCLES=3: single-beat packet, keep 1100, next grant on 4th cycle after last beat
    @(posedge clk); #1; b3.s_hdr_valid = 2'b01; #1;
    chk("g3 first grant", b3.s_hdr_ready, 2'b01);
    @(posedge clk); #1;
    b3.s_valid = 2'b01; b3.s_last = 2'b01; b3.s_keep = {4'hF, 4'b1100}; #1;
    chk("g3 beat valid", b3.m_valid, 1'b1);
    chk("g3 beat keep", b3.m_keep, 4'b1100);
    chk("g3 beat last", b3.m_last, 1'b1);
    chk("g3 beat s_ready", b3.s_ready, 2'b01);
    chk("g3 beat grant", g3, 2'b01);
    chk("g3 no grant in pkt", b3.s_hdr_ready, 2'b00);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1; b3.s_valid = 2'b00; b3.s_last = 2'b00; #1;
      chk($sformatf("g3 gap%0d hdr_ready", k), b3.s_hdr_ready, 2'b00);
      chk($sformatf("g3 gap%0d m_valid", k), b3.m_valid, 1'b0);
      chk($sformatf("g3 gap%0d busy", k), bz3, 1'b1);
      chk($sformatf("g3 gap%0d keep hold", k), b3.m_keep, 4'b1100);
    end
    @(posedge clk); #1; #1;
    chk("g3 regrant", b3.s_hdr_ready, 2'b01);
    @(posedge clk); #1; b3.s_hdr_valid = 2'b00; b3.s_valid = 2'b01; b3.s_last = 2'b01;
    @(posedge clk); #1; b3.s_valid = 2'b00; b3.s_last = 2'b00;

    // Randomized traffic against the reference model; last 1000 cycles are full contention
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        r, mr;
      logic [1:0]  hv, sv, sl, e_shr, e_gr, e_sr;
      logic [31:0] sd0, sd1, hd0, hd1, e_dat;
      logic [2:0]  hc0, hc1;
      logic        idle, e_last;
      int          w;
      @(posedge clk); #1;
      r = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      if (c >= 2000) begin
        hv = 2'b11; sv = 2'b11; mr = 1'b1; sl = 2'($urandom);
      end else begin
        hv = 2'($urandom); sv = 2'($urandom); sl = 2'($urandom); mr = ($urandom_range(0, 3) != 0);
      end
      sd0 = $urandom; sd1 = $urandom; hd0 = $urandom; hd1 = $urandom;
      hc0 = 3'($urandom); hc1 = 3'($urandom);
      rst_n = r; b1.s_hdr_valid = hv; b1.s_valid = sv; b1.s_last = sl; b1.m_ready = mr;
      b1.s_data = {sd1, sd0}; b1.s_hdr_data = {hd1, hd0}; b1.s_hdr_cnt = {hc1, hc0};
      #1;
      idle   = (m_own < 0) && (m_gap == 0);
      w      = pick(hv, m_lo);
      e_shr  = (r && idle && hv != 2'b00) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_gr   = (m_own < 0) ? 2'b00 : ((m_own == 1) ? 2'b10 : 2'b01);
      e_sr   = (m_own < 0) ? 2'b00 : ((m_own == 1) ? {mr, 1'b0} : {1'b0, mr});
      e_dat  = (m_own < 0) ? m_hold : ((m_own == 1) ? sd1 : sd0);
      e_last = (m_own < 0) ? m_lhold : sl[m_own];
      chk($sformatf("r%0d s_hdr_ready", c), b1.s_hdr_ready, e_shr);
      chk($sformatf("r%0d grant", c), g1, e_gr);
      chk($sformatf("r%0d busy", c), bz1, !idle);
      chk($sformatf("r%0d m_valid", c), b1.m_valid, (m_own >= 0) && sv[m_own]);
      chk($sformatf("r%0d m_hdr_valid", c), b1.m_hdr_valid, m_own >= 0);
      chk($sformatf("r%0d s_ready", c), b1.s_ready, e_sr);
      chk($sformatf("r%0d m_data", c), b1.m_data, e_dat);
      chk($sformatf("r%0d m_last", c), b1.m_last, e_last);
      chk($sformatf("r%0d m_hdr_data", c), b1.m_hdr_data, m_hdr);
      chk($sformatf("r%0d m_hdr_cnt", c), b1.m_hdr_cnt, m_cnt);
      if (!r) begin
        model_reset();
      end else if (idle) begin
        if (hv != 2'b00) begin
          m_own = w; m_lo = w;
          m_hdr = (w == 1) ? hd1 : hd0;
          m_cnt = (w == 1) ? hc1 : hc0;
        end
      end else if (m_own >= 0) begin
        m_hold  = (m_own == 1) ? sd1 : sd0;
        m_lhold = sl[m_own];
        if (sv[m_own] && mr && sl[m_own]) begin
          m_own = -1;
          m_gap = 1;
        end
      end else begin
        m_gap = m_gap - 1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
